inv_drive_sense: RTL and testbench

- Drive/sense sequencer that sits directly around the compmemcell inverter.
- Upstream role: registers and launches a test bit onto the inverter input (O_drive connects to inverter I_in).
- Downstream role: synchronises the inverter output (inverter O_out connects to I_sense), waits a settle window, then captures it.
- Checks the captured value against the complement of the launched bit and keeps saturating pass/fail tallies for characterisation runs.

---
 rtl/inv_test_pkg.sv | 19 +
 rtl/inv_sense_sync.sv | 29 ++
 rtl/inv_drive_sense.sv | 132 +++++++++++++
 tb/tb_inv_drive_sense.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_test_pkg.sv
// Shared encodings and default sizing for the inverter drive/sense block.
package inv_test_pkg;

    localparam int unsigned SETTLE_CYCLES_DEF = 2;
    localparam int unsigned SYNC_STAGES_DEF   = 2;
    localparam int unsigned CNT_W_DEF         = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    // Total cycles spent waiting before capture: settle time plus synchroniser depth.
    function automatic int unsigned settle_window(input int unsigned settle, input int unsigned sync);
        return settle + sync;
    endfunction

endpackage

// File: rtl/inv_sense_sync.sv
// Flop chain bringing the asynchronous inverter output into the clock domain.
module inv_sense_sync
    import inv_test_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    // Shift the sense value through STAGES flops; reset flushes to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/inv_drive_sense.sv
// Launches a test bit into the inverter, waits for settle + sync, captures and scores it.
module inv_drive_sense
    import inv_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             I_start,
    input  logic             I_bit,
    input  logic             I_clear,
    input  logic             I_sense,
    output logic             O_drive,
    output logic             O_busy,
    output logic             O_done,
    output logic             O_result,
    output logic             O_pass,
    output logic [CNT_W-1:0] O_pass_cnt,
    output logic [CNT_W-1:0] O_fail_cnt
);

    localparam int unsigned W  = settle_window(SETTLE_CYCLES, SYNC_STAGES);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              bit_q, bit_d;
    logic              drive_d, busy_d, done_d, result_d, pass_d;
    logic [CNT_W-1:0]  pass_cnt_d, fail_cnt_d;
    logic              sense_s;
    logic              match;

    inv_sense_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (I_sense),
        .q     (sense_s)
    );

    // An inverter passes when it returns the complement of what was launched.
    assign match = (sense_s != bit_q);

    // Next-state and next-output logic for the drive/settle/sample sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        drive_d    = O_drive;
        busy_d     = O_busy;
        done_d     = 1'b0;
        result_d   = O_result;
        pass_d     = O_pass;
        pass_cnt_d = O_pass_cnt;
        fail_cnt_d = O_fail_cnt;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (I_start) begin
                    bit_d   = I_bit;
                    drive_d = I_bit;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                result_d = sense_s;
                pass_d   = match;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
                if (match) begin
                    if (O_pass_cnt != CNT_MAX) pass_cnt_d = O_pass_cnt + CNT_W'(1);
                end else begin
                    if (O_fail_cnt != CNT_MAX) fail_cnt_d = O_fail_cnt + CNT_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Clear wins over a same-edge sample increment.
        if (I_clear) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
        end
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= 1'b0;
            O_drive    <= 1'b0;
            O_busy     <= 1'b0;
            O_done     <= 1'b0;
            O_result   <= 1'b0;
            O_pass     <= 1'b0;
            O_pass_cnt <= '0;
            O_fail_cnt <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            O_drive    <= drive_d;
            O_busy     <= busy_d;
            O_done     <= done_d;
            O_result   <= result_d;
            O_pass     <= pass_d;
            O_pass_cnt <= pass_cnt_d;
            O_fail_cnt <= fail_cnt_d;
        end
    end

endmodule

// File: tb/tb_inv_drive_sense.sv
// Self-checking bench: event-level model of the drive/sense operation plus directed literal checks.
module tb_inv_drive_sense;
    import inv_test_pkg::*;

    localparam int W  = int'(SETTLE_CYCLES_DEF + SYNC_STAGES_DEF);
    localparam int NS = int'(SYNC_STAGES_DEF);

    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic I_start = 1'b0;
    logic I_bit   = 1'b0;
    logic I_clear = 1'b0;
    logic I_sense;
    logic O_drive, O_busy, O_done, O_result, O_pass;
    logic [7:0] O_pass_cnt, O_fail_cnt;
    logic d2_drive, d2_busy, d2_done, d2_result, d2_pass;
    logic [1:0] d2_pass_cnt, d2_fail_cnt;

    int sense_mode = 0;     // 0 ideal inverter, 1 stuck-1, 2 stuck-0, 3 random
    logic rnd_sense = 1'b0;

    assign I_sense = (sense_mode == 0) ? ~O_drive :
                     (sense_mode == 1) ? 1'b1 :
                     (sense_mode == 2) ? 1'b0 : rnd_sense;

    inv_drive_sense u_dut (
        .clock(clock), .reset(reset), .I_start(I_start), .I_bit(I_bit), .I_clear(I_clear),
        .I_sense(I_sense), .O_drive(O_drive), .O_busy(O_busy), .O_done(O_done),
        .O_result(O_result), .O_pass(O_pass), .O_pass_cnt(O_pass_cnt), .O_fail_cnt(O_fail_cnt)
    );

    inv_drive_sense #(.CNT_W(2)) u_dut2 (
        .clock(clock), .reset(reset), .I_start(I_start), .I_bit(I_bit), .I_clear(I_clear),
        .I_sense(I_sense), .O_drive(d2_drive), .O_busy(d2_busy), .O_done(d2_done),
        .O_result(d2_result), .O_pass(d2_pass), .O_pass_cnt(d2_pass_cnt), .O_fail_cnt(d2_fail_cnt)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an operation accepted at edge e completes at edge e+W+1 and reports
    // the sense value seen NS edges before completion.
    int   edge_n   = 0;
    bit   hist[64];
    bit   armed    = 0;
    bit   inflight = 0;
    int   due      = 0;
    bit   m_bit    = 0;
    bit   e_drive = 0, e_busy = 0, e_done = 0, e_result = 0, e_pass = 0;
    int   pc = 0, fc = 0, pc2 = 0, fc2 = 0;
    int   done_cnt = 0;

    always @(posedge clock) begin
        bit r, st, b, cl, idle, got;
        r  = reset;
        st = I_start;
        b  = I_bit;
        cl = I_clear;
        hist[edge_n % 64] = I_sense;
        if (r) begin
            inflight = 0; e_drive = 0; e_busy = 0; e_done = 0; e_result = 0; e_pass = 0;
            pc = 0; fc = 0; pc2 = 0; fc2 = 0;
            armed = 1;
        end else begin
            idle   = !inflight;
            e_done = 0;
            if (inflight && edge_n == due) begin
                got      = hist[(edge_n - NS) % 64];
                e_done   = 1;
                e_result = got;
                e_pass   = (got != m_bit);
                if (e_pass) begin
                    pc  = (pc  < 255) ? pc + 1  : pc;
                    pc2 = (pc2 < 3)   ? pc2 + 1 : pc2;
                end else begin
                    fc  = (fc  < 255) ? fc + 1  : fc;
                    fc2 = (fc2 < 3)   ? fc2 + 1 : fc2;
                end
                inflight = 0;
            end
            if (idle && st) begin
                m_bit    = b;
                e_drive  = b;
                inflight = 1;
                due      = edge_n + W + 1;
            end
            e_busy = inflight;
            if (cl) begin
                pc = 0; fc = 0; pc2 = 0; fc2 = 0;
            end
        end
        edge_n++;
        #1;
        if (armed) begin
            chk("drive",     O_drive,     e_drive);
            chk("busy",      O_busy,      e_busy);
            chk("done",      O_done,      e_done);
            chk("result",    O_result,    e_result);
            chk("pass",      O_pass,      e_pass);
            chk("pass_cnt",  O_pass_cnt,  pc);
            chk("fail_cnt",  O_fail_cnt,  fc);
            chk("w2_done",   d2_done,     e_done);
            chk("w2_drive",  d2_drive,    e_drive);
            chk("w2_busy",   d2_busy,     e_busy);
            chk("w2_result", d2_result,   e_result);
            chk("w2_pass",   d2_pass,     e_pass);
            chk("w2_pcnt",   d2_pass_cnt, pc2);
            chk("w2_fcnt",   d2_fail_cnt, fc2);
        end
        if (O_done === 1'b1) done_cnt++;
    end

    // Wait (bounded) for O_done; n = edges waited, -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (O_done === 1'b1) begin
                n = k;
                return;
            end
        end
        chk("done_timeout", 1, 0);
    endtask

    // One single-pulse operation; reports edges to done and busy-cycle count.
    task automatic run_op(input logic b, output int lat, output int busy_n);
        @(negedge clock);
        I_start = 1'b1;
        I_bit   = b;
        @(posedge clock); #1;
        busy_n = (O_busy === 1'b1) ? 1 : 0;
        lat    = -1;
        @(negedge clock);
        I_start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock); #1;
            if (O_done === 1'b1) begin
                lat = k;
                break;
            end
            if (O_busy === 1'b1) busy_n++;
        end
        if (lat < 0) chk("op_timeout", 1, 0);
    endtask

    initial begin
        int lat, busy_n, n, d0;
        logic b;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_drive", O_drive, 0);
        chk("rst_busy",  O_busy,  0);
        chk("rst_done",  O_done,  0);
        chk("rst_pcnt",  O_pass_cnt, 0);
        chk("rst_fcnt",  O_fail_cnt, 0);
        @(negedge clock);
        reset = 1'b0;

        // Ideal inverter, launch 1.
        run_op(1'b1, lat, busy_n);
        chk("lat_edges",  lat, 5);
        chk("busy_cycles", busy_n, 5);
        chk("op1_drive",  O_drive, 1);
        chk("op1_result", O_result, 0);
        chk("op1_pass",   O_pass, 1);
        chk("op1_pcnt",   O_pass_cnt, 1);
        chk("op1_fcnt",   O_fail_cnt, 0);

        // Sense stuck at 1 with launch 1 fails.
        sense_mode = 1;
        run_op(1'b1, lat, busy_n);
        chk("stk_result", O_result, 1);
        chk("stk_pass",   O_pass, 0);
        chk("stk_fcnt",   O_fail_cnt, 1);
        chk("stk_pcnt",   O_pass_cnt, 1);
        sense_mode = 0;

        // Extra starts during SETTLE and SAMPLE are ignored.
        d0 = done_cnt;
        @(negedge clock); I_start = 1'b1; I_bit = 1'b0;
        @(negedge clock); I_start = 1'b0;
        @(negedge clock); I_start = 1'b1;
        repeat (4) @(negedge clock);
        I_start = 1'b0;
        repeat (10) @(negedge clock);
        chk("ext_dones", done_cnt - d0, 1);
        chk("ext_pcnt",  O_pass_cnt, 2);

        // Start held high, alternating bits: back-to-back operations every 6 cycles.
        b = 1'b1;
        @(negedge clock); I_start = 1'b1; I_bit = b;
        for (int op = 0; op < 6; op++) begin
            wait_done(n);
            chk("held_spacing", n, 6);
            chk("held_drive", O_drive, b);
            chk("held_pass",  O_pass, 1);
            b = ~b;
            @(negedge clock);
            I_bit = b;
            if (op == 5) I_start = 1'b0;
        end
        repeat (8) @(negedge clock);
        chk("held_pcnt", O_pass_cnt, 8);

        // Reset during SETTLE aborts; next operation runs normally.
        @(negedge clock); I_start = 1'b1; I_bit = 1'b1;
        @(negedge clock); I_start = 1'b0;
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        chk("mid_drive", O_drive, 0);
        chk("mid_busy",  O_busy, 0);
        chk("mid_done",  O_done, 0);
        chk("mid_pcnt",  O_pass_cnt, 0);
        @(negedge clock); reset = 1'b0;
        d0 = done_cnt;
        repeat (10) @(negedge clock);
        chk("mid_nodone", done_cnt - d0, 0);
        run_op(1'b1, lat, busy_n);
        chk("mid_lat",  lat, 5);
        chk("mid_pcnt2", O_pass_cnt, 1);

        // Long pass run saturates both counter widths.
        @(negedge clock); I_start = 1'b1;
        repeat (2000) begin
            @(negedge clock);
            I_bit = 1'($urandom);
        end
        I_start = 1'b0;
        repeat (10) @(negedge clock);
        chk("sat_pcnt8", O_pass_cnt, 255);
        chk("sat_pcnt2", d2_pass_cnt, 3);
        chk("sat_fcnt8", O_fail_cnt, 0);

        // Clear on the sample edge beats the increment.
        @(negedge clock); I_start = 1'b1; I_bit = 1'b1;
        @(negedge clock); I_start = 1'b0;
        repeat (4) @(negedge clock);
        I_clear = 1'b1;
        @(posedge clock); #1;
        chk("clr_done",  O_done, 1);
        chk("clr_pcnt8", O_pass_cnt, 0);
        chk("clr_pcnt2", d2_pass_cnt, 0);
        @(negedge clock); I_clear = 1'b0;

        // Randomised traffic against the model.
        repeat (3000) begin
            @(negedge clock);
            I_start   = 1'(($urandom % 4) != 0);
            I_bit     = 1'($urandom);
            I_clear   = 1'(($urandom % 40) == 0);
            reset     = 1'(($urandom % 400) == 0);
            rnd_sense = 1'($urandom);
            if (($urandom % 50) == 0) sense_mode = int'($urandom % 4);
        end
        @(negedge clock);
        I_start = 1'b0; I_clear = 1'b0; reset = 1'b0;
        repeat (10) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
